// File: rtl/hwag_cfg_seq.sv
// hwag_cfg_seq: writes the HWAG boot register table after reset, then arbitrates the register bus for a host port.
// Define HWAG_CFG_VERIFY_EN to read the table back and flag the first mismatching entry.
module hwag_cfg_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        reboot,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic        cfg_done,
  output logic        cfg_fault,
  output logic [7:0]  fault_addr
);

  localparam int N_ENTRIES = 12;
  localparam logic [3:0] END_IDX = 4'(N_ENTRIES);
`ifdef HWAG_CFG_VERIFY_EN
  localparam logic [3:0] LAST_IDX = 4'(N_ENTRIES - 1);
`endif

  typedef enum logic [1:0] {BOOT_WR, VERIFY_RD, READY, FAULT} state_t;

  state_t      state;
  logic [3:0]  idx;
  logic        reboot_pend;
  logic        in_serve;
  logic        busy;
  logic        finishing;
  logic        do_reboot;
  logic        accept;
  logic [23:0] cur;
  logic [23:0] first;
`ifdef HWAG_CFG_VERIFY_EN
  logic [23:0] nxt;
`endif

  // Each entry packs {addr, data}; CR0 (addr 63) goes last so the generator starts fully configured.
  function automatic logic [23:0] boot_entry(input logic [3:0] i);
    logic [23:0] e;
    case (i)
      4'd0:    e = {8'd0,   16'd128};
      4'd1:    e = {8'd1,   16'd0};
      4'd2:    e = {8'd2,   16'd65535};
      4'd3:    e = {8'd3,   16'd0};
      4'd4:    e = {8'd4,   16'd57};
      4'd5:    e = {8'd5,   16'd4};
      4'd6:    e = {8'd6,   16'd3839};
      4'd7:    e = {8'd65,  16'd2};
      4'd8:    e = {8'd70,  16'd2};
      4'd9:    e = {8'd127, 16'd1024};
      4'd10:   e = {8'd129, 16'd3830};
      4'd11:   e = {8'd63,  16'd7};
      default: e = 24'd0;
    endcase
    return e;
  endfunction

  // The host may also be taken on the very edge the boot sequence completes.
  always_comb begin
    in_serve = (state == READY) || (state == FAULT);
    busy     = in_serve && (reg_we || reg_re);
    cur      = boot_entry(idx);
    first    = boot_entry(4'd0);
`ifdef HWAG_CFG_VERIFY_EN
    nxt       = boot_entry(idx + 4'd1);
    finishing = (state == VERIFY_RD) && (idx == LAST_IDX) && (reg_rdata == cur[15:0]);
`else
    finishing = (state == BOOT_WR) && (idx == END_IDX);
`endif
    do_reboot = in_serve && !busy && (reboot || reboot_pend);
    accept    = (in_serve || finishing) && !busy && !do_reboot && host_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT_WR;
      idx         <= '0;
      reboot_pend <= 1'b0;
      host_ack    <= 1'b0;
      host_rdata  <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      cfg_done    <= 1'b0;
`ifdef HWAG_CFG_VERIFY_EN
      cfg_fault   <= 1'b0;
      fault_addr  <= '0;
`endif
    end else begin
      reg_we   <= 1'b0;
      reg_re   <= 1'b0;
      host_ack <= 1'b0;
      case (state)
        BOOT_WR: begin
          if (idx != END_IDX) begin
            reg_we    <= 1'b1;
            reg_addr  <= cur[23:16];
            reg_wdata <= cur[15:0];
            idx       <= idx + 4'd1;
          end else begin
`ifdef HWAG_CFG_VERIFY_EN
            reg_re   <= 1'b1;
            reg_addr <= first[23:16];
            idx      <= '0;
            state    <= VERIFY_RD;
`else
            cfg_done <= 1'b1;
            state    <= READY;
`endif
          end
        end
`ifdef HWAG_CFG_VERIFY_EN
        // Read data for the entry on the bus is compared at the edge that ends its strobe.
        VERIFY_RD: begin
          if (reg_rdata != cur[15:0]) begin
            cfg_fault  <= 1'b1;
            fault_addr <= cur[23:16];
            state      <= FAULT;
          end else if (idx == LAST_IDX) begin
            cfg_done <= 1'b1;
            state    <= READY;
          end else begin
            reg_re   <= 1'b1;
            reg_addr <= nxt[23:16];
            idx      <= idx + 4'd1;
          end
        end
`endif
        default: begin
          if (busy) begin
            host_ack <= 1'b1;
            if (reg_re) host_rdata <= reg_rdata;
            if (reboot) reboot_pend <= 1'b1;
          end else if (do_reboot) begin
            reboot_pend <= 1'b0;
            cfg_done    <= 1'b0;
`ifdef HWAG_CFG_VERIFY_EN
            cfg_fault   <= 1'b0;
            fault_addr  <= '0;
`endif
            reg_we      <= 1'b1;
            reg_addr    <= first[23:16];
            reg_wdata   <= first[15:0];
            idx         <= 4'd1;
            state       <= BOOT_WR;
          end
        end
      endcase
      if (accept) begin
        reg_we    <= host_we;
        reg_re    <= !host_we;
        reg_addr  <= host_addr;
        reg_wdata <= host_we ? host_wdata : 16'd0;
      end
    end
  end

`ifndef HWAG_CFG_VERIFY_EN
  assign cfg_fault  = 1'b0;
  assign fault_addr = 8'd0;
`endif

endmodule

// File: tb/tb_hwag_cfg_seq.sv
// tb_hwag_cfg_seq: scoreboard bench for hwag_cfg_seq with a combinational-read register model.
// Builds with or without HWAG_CFG_VERIFY_EN; verify-only scenarios follow the same macro.
module tb_hwag_cfg_seq;

`ifdef HWAG_CFG_VERIFY_EN
  localparam int DONE_OFS = 24;
`else
  localparam int DONE_OFS = 12;
`endif

  typedef struct {
    int          edge_no;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
  } bus_t;

  typedef struct {
    int          edge_no;
    logic [15:0] data;
  } ack_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reboot = 1'b0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [15:0] reg_rdata;
  logic        cfg_done;
  logic        cfg_fault;
  logic [7:0]  fault_addr;

  logic        corrupt = 1'b0;
  logic [15:0] mem [256];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] last_rd = '0;
  bus_t        bus_q[$];
  ack_t        ack_q[$];

  int unsigned tbl_addr [12] = '{0, 1, 2, 3, 4, 5, 6, 65, 70, 127, 129, 63};
  int unsigned tbl_data [12] = '{128, 0, 65535, 0, 57, 4, 3839, 2, 2, 1024, 3830, 7};

  hwag_cfg_seq dut (
    .clk(clk), .rst(rst), .reboot(reboot),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .cfg_done(cfg_done), .cfg_fault(cfg_fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  // Register file model: writes land on the clock edge, reads are combinational on reg_addr.
  initial for (int i = 0; i < 256; i++) mem[i] = 16'd0;
  always @(posedge clk) if (rst && reg_we) mem[reg_addr] <= reg_wdata;
  always_comb reg_rdata = (corrupt && reg_addr == 8'd70) ? 16'd3 : mem[reg_addr];

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_bus(input int e, input logic we, input logic [7:0] a, input logic [15:0] d);
    bus_t b;
    b.edge_no = e; b.we = we; b.addr = a; b.data = d;
    bus_q.push_back(b);
  endtask

  task automatic push_ack(input int e, input logic [15:0] d);
    ack_t k;
    k.edge_no = e; k.data = d;
    ack_q.push_back(k);
  endtask

  // Table writes from edge base onward, then (with verify) the first n_rd read-backs.
  task automatic push_boot(input int base, input int n_rd);
    for (int i = 0; i < 12; i++) push_bus(base + i, 1'b1, 8'(tbl_addr[i]), 16'(tbl_data[i]));
`ifdef HWAG_CFG_VERIFY_EN
    for (int i = 0; i < n_rd; i++) push_bus(base + 12 + i, 1'b0, 8'(tbl_addr[i]), 16'd0);
`else
    if (n_rd < 0) $display("[TB] note: negative read count");
`endif
  endtask

  task automatic goto(input int k);
    int guard = 0;
    while (cyc < k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) checkOutput("goto_cycle", cyc, k);
  endtask

  // One host access starting at the current negedge; request dropped once host_ack is seen.
  task automatic applyStimulus(input logic we, input logic [7:0] a, input logic [15:0] d, input logic [15:0] exp_rd);
    int c;
    c = cyc;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    push_bus(c + 1, we, a, we ? d : 16'd0);
    if (!we) last_rd = exp_rd;
    push_ack(c + 2, last_rd);
    @(negedge clk);
    @(negedge clk);
    host_req = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    checkOutput({tag, "_reg_we"}, reg_we, 0);
    checkOutput({tag, "_reg_re"}, reg_re, 0);
    checkOutput({tag, "_reg_addr"}, reg_addr, 0);
    checkOutput({tag, "_reg_wdata"}, reg_wdata, 0);
    checkOutput({tag, "_host_ack"}, host_ack, 0);
    checkOutput({tag, "_host_rdata"}, host_rdata, 0);
    checkOutput({tag, "_cfg_done"}, cfg_done, 0);
    checkOutput({tag, "_cfg_fault"}, cfg_fault, 0);
    checkOutput({tag, "_fault_addr"}, fault_addr, 0);
  endtask

  // Monitor: every strobe or ack the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      if (reg_we || reg_re) begin
        checkOutput("strobe_excl", reg_we & reg_re, 0);
        if (bus_q.size() == 0) begin
          checkOutput("unexpected_access_addr", reg_addr, 256);
        end else begin
          bus_t e;
          e = bus_q.pop_front();
          checkOutput("bus_edge", cyc, e.edge_no);
          checkOutput("bus_we", reg_we, e.we);
          checkOutput("bus_addr", reg_addr, e.addr);
          if (e.we) checkOutput("bus_wdata", reg_wdata, e.data);
        end
      end
      if (host_ack) begin
        if (ack_q.size() == 0) begin
          checkOutput("unexpected_ack", 1, 0);
        end else begin
          ack_t k;
          k = ack_q.pop_front();
          checkOutput("ack_edge", cyc, k.edge_no);
          checkOutput("ack_rdata", host_rdata, k.data);
        end
      end
    end
  end

  initial begin
    int c;
    #2 rst = 1'b0;
    #10;
    check_idle_outputs("reset");
    push_boot(1, 12);
    @(negedge clk);
    rst = 1'b1;

    // Host write held from edge 3 is only served once the boot completes.
    goto(2);
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd63; host_wdata = 16'd0;
    push_bus(DONE_OFS + 1, 1'b1, 8'd63, 16'd0);
    push_ack(DONE_OFS + 2, 16'd0);
    goto(DONE_OFS);
    checkOutput("done_before", cfg_done, 0);
    goto(DONE_OFS + 1);
    checkOutput("done_rise", cfg_done, 1);
    checkOutput("no_fault", cfg_fault, 0);
    goto(DONE_OFS + 2);
    host_req = 1'b0;

    applyStimulus(1'b0, 8'd4, 16'd0, 16'd57);
    applyStimulus(1'b1, 8'd200, 16'hBEEF, 16'd0);
    applyStimulus(1'b0, 8'd200, 16'd0, 16'hBEEF);
    applyStimulus(1'b0, 8'd63, 16'd0, 16'd0);
    applyStimulus(1'b0, 8'd0, 16'd0, 16'd128);

    // Reboot arriving during an in-flight read waits for its ack.
    c = cyc;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd5;
    push_bus(c + 1, 1'b0, 8'd5, 16'd0);
    push_ack(c + 2, 16'd4);
    last_rd = 16'd4;
    @(negedge clk);
    host_req = 1'b0;
    reboot = 1'b1;
    @(negedge clk);
    reboot = 1'b0;
    push_boot(c + 3, 12);
    goto(c + 3);
    checkOutput("reboot_done_clr", cfg_done, 0);
    goto(c + 2 + DONE_OFS);
    checkOutput("reboot_done_before", cfg_done, 0);
    goto(c + 3 + DONE_OFS);
    checkOutput("reboot_done_rise", cfg_done, 1);

    // Reset asserted at edge 6 of a boot aborts it; writes restart from entry 0.
    c = cyc;
    reboot = 1'b1;
    @(negedge clk);
    reboot = 1'b0;
    push_boot(c + 1, 12);
    goto(c + 6);
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("midreset");
    bus_q.delete();
    last_rd = 16'd0;
    push_boot(1, 12);
    @(negedge clk);
    rst = 1'b1;
    goto(DONE_OFS + 1);
    checkOutput("restart_done", cfg_done, 1);

`ifdef HWAG_CFG_VERIFY_EN
    // Corrupted read-back of addr 70 stops verification at its compare edge.
    @(negedge clk);
    corrupt = 1'b1;
    rst = 1'b0;
    #1;
    bus_q.delete();
    last_rd = 16'd0;
    push_boot(1, 9);
    @(negedge clk);
    rst = 1'b1;
    goto(21);
    checkOutput("fault_before", cfg_fault, 0);
    goto(22);
    checkOutput("fault_set", cfg_fault, 1);
    checkOutput("fault_addr", fault_addr, 70);
    checkOutput("fault_no_done", cfg_done, 0);
    goto(27);
    checkOutput("fault_done_stays0", cfg_done, 0);
    applyStimulus(1'b0, 8'd70, 16'd0, 16'd3);
    corrupt = 1'b0;
    c = cyc;
    reboot = 1'b1;
    push_boot(c + 1, 12);
    @(negedge clk);
    reboot = 1'b0;
    checkOutput("fault_clr", cfg_fault, 0);
    checkOutput("fault_addr_clr", fault_addr, 0);
    goto(c + 25);
    checkOutput("refault_done", cfg_done, 1);
`endif

    repeat (5) @(negedge clk);
    checkOutput("bus_q_drained", bus_q.size(), 0);
    checkOutput("ack_q_drained", ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
